// File: rtl/led_pwm_fader.sv
// -----------------------------------------------------------------------------
// led_pwm_fader
//
// Drives every LED filament (red/green/blue of each color LED, plus each
// single-color LED) with an 8-bit PWM waveform. The period is 255 PWM ticks,
// and each tick is parm_pwm_prescale clocks long.
//
// Channel targets are sampled only at the period boundary. A duty change
// therefore never lands in the middle of a period, so the outputs are
// glitch-free.
//
// Optional feature macro: LED_PWM_FADE_EN
//   defined   - each duty slews toward its target by parm_fade_step per period
//   undefined - each duty jumps straight to its target at every boundary
// -----------------------------------------------------------------------------
module led_pwm_fader #(
  parameter  int parm_color_led_count = 4,
  parameter  int parm_basic_led_count = 4,
  parameter  int parm_pwm_prescale    = 16,
  parameter  int parm_fade_step       = 4,
  localparam int c_color_value_upper  = 8*parm_color_led_count-1,
  localparam int c_basic_value_upper  = 8*parm_basic_led_count-1
) (
  input  logic                            i_clk,
  input  logic                            i_srst,
  input  logic [c_color_value_upper:0]    i_color_led_red_value,
  input  logic [c_color_value_upper:0]    i_color_led_green_value,
  input  logic [c_color_value_upper:0]    i_color_led_blue_value,
  input  logic [c_basic_value_upper:0]    i_basic_led_lumin_value,
  output logic [parm_color_led_count-1:0] o_color_led_red,
  output logic [parm_color_led_count-1:0] o_color_led_green,
  output logic [parm_color_led_count-1:0] o_color_led_blue,
  output logic [parm_basic_led_count-1:0] o_basic_led,
  output logic                            o_period_strobe
);

  // Channel order: reds, then greens, then blues, then basic LEDs.
  localparam int c_cnum       = parm_color_led_count;
  localparam int c_chan_count = 3*c_cnum + parm_basic_led_count;

  localparam int                   c_presc_w    = (parm_pwm_prescale > 1) ? $clog2(parm_pwm_prescale) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(parm_pwm_prescale - 1);
  localparam logic [7:0]           c_pwm_last   = 8'd254;

  // Elaboration-time parameter sanity checks.
  if (parm_pwm_prescale < 1) begin : g_bad_prescale
    $error("led_pwm_fader: parm_pwm_prescale must be at least 1");
  end
  if (parm_fade_step < 1 || parm_fade_step > 255) begin : g_bad_fade_step
    $error("led_pwm_fader: parm_fade_step must be within 1..255");
  end

  logic [c_presc_w-1:0]    presc_q, presc_d;
  logic [7:0]              pwm_q, pwm_d;
  logic                    tick;
  logic                    boundary;
  logic                    strobe_q, strobe_d;
  logic [7:0]              in_value [c_chan_count];
  logic [7:0]              target_q [c_chan_count];
  logic [7:0]              target_d [c_chan_count];
  logic [7:0]              duty_q   [c_chan_count];
  logic [7:0]              duty_d   [c_chan_count];
  logic [c_chan_count-1:0] led_q, led_d;

`ifdef LED_PWM_FADE_EN
  // Moves duty one step toward target. It lands exactly on the target when
  // the target is within one step, so it never overshoots and never wraps.
  function automatic logic [7:0] fade_next(input logic [7:0] duty,
                                           input logic [7:0] target);
    logic signed [8:0] diff;
    logic        [8:0] mag;
    diff = $signed({1'b0, target}) - $signed({1'b0, duty});
    mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= 9'(parm_fade_step)) begin
      return target;
    end else if (diff[8]) begin
      return duty - 8'(parm_fade_step);
    end else begin
      return duty + 8'(parm_fade_step);
    end
  endfunction
`endif

  // Flatten the four packed input buses into one per-channel array.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // or partial assignment; a path that leaves a variable unassigned would
    // infer a latch.
    for (int ch = 0; ch < c_chan_count; ch++) begin
      in_value[ch] = '0;
    end
    for (int n = 0; n < c_cnum; n++) begin
      in_value[n]            = i_color_led_red_value[8*n +: 8];
      in_value[c_cnum + n]   = i_color_led_green_value[8*n +: 8];
      in_value[2*c_cnum + n] = i_color_led_blue_value[8*n +: 8];
    end
    for (int n = 0; n < parm_basic_led_count; n++) begin
      in_value[3*c_cnum + n] = i_basic_led_lumin_value[8*n +: 8];
    end
  end

  // Prescaler, PWM counter (0..254), and period-boundary detection.
  always_comb begin
    tick     = (presc_q == c_presc_last);
    boundary = tick && (pwm_q == c_pwm_last);
    presc_d  = tick ? '0 : presc_q + c_presc_w'(1);
    pwm_d    = pwm_q;
    if (tick) begin
      pwm_d = (pwm_q == c_pwm_last) ? 8'd0 : pwm_q + 8'd1;
    end
    strobe_d = boundary;
  end

  // Per-channel logic: latch the target and update the duty at the boundary;
  // otherwise compare the PWM counter against the duty.
  always_comb begin
    for (int ch = 0; ch < c_chan_count; ch++) begin
      target_d[ch] = target_q[ch];
      duty_d[ch]   = duty_q[ch];
      led_d[ch]    = (pwm_q < duty_q[ch]);
      if (boundary) begin
        target_d[ch] = in_value[ch];
`ifdef LED_PWM_FADE_EN
        duty_d[ch]   = fade_next(duty_q[ch], in_value[ch]);
`else
        duty_d[ch]   = in_value[ch];
`endif
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge value of every other register.
    if (i_srst) begin
      presc_q  <= '0;
      pwm_q    <= '0;
      // NOTE: the per-channel arrays are ordinary flops, not RAM. They are
      // cleared here so that every LED starts dark and every fade starts at 0.
      target_q <= '{default: '0};
      duty_q   <= '{default: '0};
      led_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      pwm_q    <= pwm_d;
      target_q <= target_d;
      duty_q   <= duty_d;
      led_q    <= led_d;
      strobe_q <= strobe_d;
    end
  end

  assign o_color_led_red   = led_q[c_cnum-1:0];
  assign o_color_led_green = led_q[2*c_cnum-1:c_cnum];
  assign o_color_led_blue  = led_q[3*c_cnum-1:2*c_cnum];
  assign o_basic_led       = led_q[c_chan_count-1:3*c_cnum];
  assign o_period_strobe   = strobe_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_fader
//
// Directed bench with three instances that share the clock and the input buses.
// Each instance has its own reset:
//   dut_a - prescale 16 (reset and first-strobe timing)
//   dut_b - prescale 2  (static duty and latch isolation)
//   dut_c - prescale 1  (channel independence, fade ramps, reset mid-ramp)
//
// Channel c of the 16-bit pin view is:
//   red[c]        for c = 0..3
//   green[c-4]    for c = 4..7
//   blue[c-8]     for c = 8..11
//   basic[c-12]   for c = 12..15
//
// Expected high counts per period are duty*prescale. The duty comes from a
// small step model: with LED_PWM_FADE_EN it moves by at most 4 per period,
// otherwise it equals the target.
// -----------------------------------------------------------------------------
module tb_led_pwm_fader;

  localparam int FADE = 4;
  localparam int P_A  = 16;
  localparam int P_B  = 2;
  localparam int P_C  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst_a, srst_b, srst_c;
  logic [7:0]  tgt [16];
  logic [31:0] red_v, green_v, blue_v, lumin_v;

  logic [3:0] red_a, green_a, blue_a, basic_a;
  logic [3:0] red_b, green_b, blue_b, basic_b;
  logic [3:0] red_c, green_c, blue_c, basic_c;
  logic       strobe_a, strobe_b, strobe_c;
  logic [15:0] pins_a, pins_b, pins_c;

  int checks = 0;
  int errors = 0;
  int hi_cnt [16];
  int dm     [16];
  int n_edges;
  int periods;

  always_comb begin
    red_v   = '0;
    green_v = '0;
    blue_v  = '0;
    lumin_v = '0;
    for (int n = 0; n < 4; n++) begin
      red_v[8*n +: 8]   = tgt[n];
      green_v[8*n +: 8] = tgt[4+n];
      blue_v[8*n +: 8]  = tgt[8+n];
      lumin_v[8*n +: 8] = tgt[12+n];
    end
  end

  assign pins_a = {basic_a, blue_a, green_a, red_a};
  assign pins_b = {basic_b, blue_b, green_b, red_b};
  assign pins_c = {basic_c, blue_c, green_c, red_c};

  led_pwm_fader #(.parm_color_led_count(4), .parm_basic_led_count(4),
                  .parm_pwm_prescale(P_A), .parm_fade_step(FADE)) dut_a (
    .i_clk(clk), .i_srst(srst_a),
    .i_color_led_red_value(red_v), .i_color_led_green_value(green_v),
    .i_color_led_blue_value(blue_v), .i_basic_led_lumin_value(lumin_v),
    .o_color_led_red(red_a), .o_color_led_green(green_a),
    .o_color_led_blue(blue_a), .o_basic_led(basic_a),
    .o_period_strobe(strobe_a));

  led_pwm_fader #(.parm_color_led_count(4), .parm_basic_led_count(4),
                  .parm_pwm_prescale(P_B), .parm_fade_step(FADE)) dut_b (
    .i_clk(clk), .i_srst(srst_b),
    .i_color_led_red_value(red_v), .i_color_led_green_value(green_v),
    .i_color_led_blue_value(blue_v), .i_basic_led_lumin_value(lumin_v),
    .o_color_led_red(red_b), .o_color_led_green(green_b),
    .o_color_led_blue(blue_b), .o_basic_led(basic_b),
    .o_period_strobe(strobe_b));

  led_pwm_fader #(.parm_color_led_count(4), .parm_basic_led_count(4),
                  .parm_pwm_prescale(P_C), .parm_fade_step(FADE)) dut_c (
    .i_clk(clk), .i_srst(srst_c),
    .i_color_led_red_value(red_v), .i_color_led_green_value(green_v),
    .i_color_led_blue_value(blue_v), .i_basic_led_lumin_value(lumin_v),
    .o_color_led_red(red_c), .o_color_led_green(green_c),
    .o_color_led_blue(blue_c), .o_basic_led(basic_c),
    .o_period_strobe(strobe_c));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int presc_of(input int sel);
    case (sel)
      0:       return P_A;
      1:       return P_B;
      default: return P_C;
    endcase
  endfunction

  function automatic logic [15:0] pins_of(input int sel);
    case (sel)
      0:       return pins_a;
      1:       return pins_b;
      default: return pins_c;
    endcase
  endfunction

  function automatic logic strobe_of(input int sel);
    case (sel)
      0:       return strobe_a;
      1:       return strobe_b;
      default: return strobe_c;
    endcase
  endfunction

  // Duty after one boundary, given the old duty d and the target t.
  function automatic int step_model(input int d, input int t);
`ifdef LED_PWM_FADE_EN
    if (t > d + FADE) return d + FADE;
    if (t + FADE < d) return d - FADE;
    return t;
`else
    return t;
`endif
  endfunction

  task automatic update_model();
    for (int ch = 0; ch < 16; ch++) dm[ch] = step_model(dm[ch], int'(tgt[ch]));
  endtask

  task automatic reset_dut(input int sel);
    @(negedge clk);
    case (sel)
      0:       srst_a = 1'b1;
      1:       srst_b = 1'b1;
      default: srst_c = 1'b1;
    endcase
    repeat (2) @(negedge clk);
    case (sel)
      0:       srst_a = 1'b0;
      1:       srst_b = 1'b0;
      default: srst_c = 1'b0;
    endcase
    for (int ch = 0; ch < 16; ch++) dm[ch] = 0;
  endtask

  // Counts negedges until the strobe is seen high. n = 1 is the first negedge.
  task automatic wait_strobe(input int sel, output int n);
    bit found = 1'b0;
    n = 0;
    while (!found && n < 255*presc_of(sel) + 20) begin
      @(negedge clk);
      n++;
      if (strobe_of(sel)) found = 1'b1;
    end
    if (!found) check($sformatf("strobe_timeout_dut%0d", sel), 0, 1);
  endtask

  // Starts at a strobe negedge and counts the high samples of one full period.
  // Optionally changes one target right after sample chg_at.
  task automatic measure_next(input int sel, input int chg_at,
                              input int chg_ch, input int chg_val);
    int n;
    logic [15:0] p;
    n = 255*presc_of(sel);
    for (int ch = 0; ch < 16; ch++) hi_cnt[ch] = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      p = pins_of(sel);
      for (int ch = 0; ch < 16; ch++) if (p[ch]) hi_cnt[ch]++;
      if (k == chg_at) tgt[chg_ch] = 8'(chg_val);
    end
  endtask

  task automatic check_period(input string tag, input int sel);
    for (int ch = 0; ch < 16; ch++)
      check($sformatf("%s_ch%0d", tag, ch), hi_cnt[ch], dm[ch]*presc_of(sel));
    check($sformatf("%s_strobe", tag), int'(strobe_of(sel)), 1);
  endtask

  function automatic bit converged();
    for (int ch = 0; ch < 16; ch++) if (dm[ch] != int'(tgt[ch])) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    // ---------------- Reset with all inputs 0xFF --------------------------
    srst_a = 1'b1;
    srst_b = 1'b1;
    srst_c = 1'b1;
    for (int ch = 0; ch < 16; ch++) tgt[ch] = 8'hFF;
    repeat (5) @(negedge clk);
    check("reset_pins_a",   int'(pins_a),   0);
    check("reset_strobe_a", int'(strobe_a), 0);
    check("reset_pins_b",   int'(pins_b),   0);
    check("reset_pins_c",   int'(pins_c),   0);
    srst_a = 1'b0;
    srst_b = 1'b0;
    srst_c = 1'b0;
    // The boundary state (pwm 254, presc 15) is reached after 4079 non-reset
    // edges, and the strobe is registered on the next edge: 4080 edges after
    // release, or 4081 when the last reset-sampling edge is also counted.
    wait_strobe(0, n_edges);
    check("first_strobe_edges", n_edges, 4080);
    @(negedge clk);
    check("strobe_one_clock", int'(strobe_a), 0);

    // ---------------- Static duty, prescale 2 -----------------------------
    for (int ch = 0; ch < 16; ch++) tgt[ch] = 8'h00;
    reset_dut(1);
    tgt[0] = 8'h80;
    wait_strobe(1, n_edges);
    update_model();
    measure_next(1, -1, 0, 0);
    check_period("static_80", 1);           // instant: 256 high, 254 low
    update_model();
    tgt[0] = 8'h00;                         // arrives after the boundary
    measure_next(1, -1, 0, 0);
    check_period("static_80_hold", 1);
    update_model();
    tgt[0] = 8'hFF;
    measure_next(1, -1, 0, 0);
    check_period("static_00", 1);           // instant: never high
    update_model();
    measure_next(1, -1, 0, 0);
    check_period("static_ff", 1);           // instant: all 510 high

    // ---------------- Latch isolation on green[1] (channel 5) --------------
    for (int ch = 0; ch < 16; ch++) tgt[ch] = 8'h00;
    reset_dut(1);
    tgt[5] = 8'h40;
    wait_strobe(1, n_edges);
    update_model();
    measure_next(1, 200, 5, 8'hC0);         // mid-period change
    check_period("latch_mid", 1);           // instant: 128
    update_model();
    measure_next(1, 255*P_B-2, 5, 8'h10);   // change on the boundary cycle
    check_period("latch_pre", 1);           // instant: 384
    update_model();
    measure_next(1, -1, 0, 0);
    check_period("latch_capture", 1);       // instant: 32

    // ---------------- Channel independence, prescale 1 ---------------------
    for (int ch = 0; ch < 16; ch++) tgt[ch] = 8'h00;
    reset_dut(2);
    for (int ch = 0; ch < 16; ch++) tgt[ch] = 8'(ch*15 + 7);
    wait_strobe(2, n_edges);
    update_model();
    for (int p = 0; p < 70; p++) begin
      measure_next(2, -1, 0, 0);
      check_period("indep", 2);
      if (converged() && p >= 1) break;
      update_model();
    end

    // ---------------- Fade ramp on lumin[2] (channel 14) -------------------
    for (int ch = 0; ch < 16; ch++) tgt[ch] = 8'h00;
    reset_dut(2);
    tgt[14] = 8'hFF;
    wait_strobe(2, n_edges);
    update_model();
    periods = 1;
    for (int p = 0; p < 70; p++) begin
      measure_next(2, -1, 0, 0);
      check_period("ramp_up", 2);
      if (dm[14] == 255) break;
      update_model();
      periods++;
    end
`ifdef LED_PWM_FADE_EN
    check("ramp_up_periods", periods, 64);  // 4,8,..,252,255
`else
    check("ramp_up_periods", periods, 1);
`endif
    update_model();
    tgt[14] = 8'h02;
    measure_next(2, -1, 0, 0);
    check_period("ramp_hold", 2);
    update_model();
    periods = 1;
    for (int p = 0; p < 70; p++) begin
      measure_next(2, -1, 0, 0);
      check_period("ramp_down", 2);
      if (dm[14] == 2) break;
      update_model();
      periods++;
    end
`ifdef LED_PWM_FADE_EN
    check("ramp_down_periods", periods, 64); // 251,..,3,2
`else
    check("ramp_down_periods", periods, 1);
`endif

    // ---------------- Reset in the middle of a ramp ------------------------
    for (int ch = 0; ch < 16; ch++) tgt[ch] = 8'h00;
    reset_dut(2);
    tgt[14] = 8'hFF;
    wait_strobe(2, n_edges);
    update_model();
    for (int p = 0; p < 10; p++) begin
      measure_next(2, -1, 0, 0);
      check_period("pre_reset", 2);
      update_model();
    end
    repeat (100) @(negedge clk);
    srst_c = 1'b1;
    @(negedge clk);
    check("midreset_pins",   int'(pins_c),   0);
    check("midreset_strobe", int'(strobe_c), 0);
    @(negedge clk);
    srst_c = 1'b0;
    for (int ch = 0; ch < 16; ch++) dm[ch] = 0;
    wait_strobe(2, n_edges);
    check("midreset_first_strobe", n_edges, 255);
    update_model();
    measure_next(2, -1, 0, 0);
    check_period("resume", 2);              // fade: 4, instant: 255
    update_model();
    measure_next(2, -1, 0, 0);
    check_period("resume2", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Consumer end of the LED palette path. Accepts the per-filament 8-bit palette values (red/green/blue for each color LED, luminance for each basic LED) and drives the LED pins with 8-bit PWM. Optionally slews each channel's duty toward its target by a fixed step per PWM period, so state changes in the SF Tester FSM fade rather than snap. Sits between the palette updater and the board top-level LED pins.

## Interface

- parm_color_led_count, 4, number of RGB LEDs
- parm_basic_led_count, 4, number of single-color LEDs
- parm_pwm_prescale, 16, clocks per PWM tick (≥1)
- parm_fade_step, 4, duty change per PWM period when fading (1..255)
- c_color_value_upper / c_basic_value_upper, 8*count-1, derived; not overridden

- i_clk  in  1  system clock; single clock domain
- i_srst  in  1  synchronous, active-high reset
- i_color_led_red_value  in  8*parm_color_led_count  red targets; LED n in bits [8n+7:8n]
- i_color_led_green_value  in  8*parm_color_led_count  green targets
- i_color_led_blue_value  in  8*parm_color_led_count  blue targets
- i_basic_led_lumin_value  in  8*parm_basic_led_count  basic LED targets
- o_color_led_red  out  parm_color_led_count  PWM pin per red filament
- o_color_led_green  out  parm_color_led_count  PWM pin per green filament
- o_color_led_blue  out  parm_color_led_count  PWM pin per blue filament
- o_basic_led  out  parm_basic_led_count  PWM pin per basic LED
- o_period_strobe  out  1  one-clock pulse at each PWM period boundary

## Operation

- Prescaler: counts 0..parm_pwm_prescale-1; tick asserted on the cycle it equals parm_pwm_prescale-1, then wraps to 0.
- PWM counter: 8-bit, advances on tick, range 0..254, wraps 254→0. Period = 255 ticks = 255*parm_pwm_prescale clocks.
- Period boundary: the tick cycle with PWM counter = 254. On that cycle:
  - all input values latched into per-channel target registers (inputs between boundaries are ignored; glitch-free duty changes);
  - per-channel duty register updated (see Configuration);
  - o_period_strobe asserted the following cycle for exactly one clock.
- Compare: channel output = (PWM counter < duty). Duty 0 → constant low; duty 255 → constant high; duty d → high d of 255 ticks.
- Fade arithmetic: 9-bit signed difference diff = target − duty. If |diff| ≤ parm_fade_step, duty := target; else duty := duty ± parm_fade_step. Never overshoots, never wraps.
- All channels independent; identical logic per channel.

## Timing

- Reset (i_srst high on a clock edge): prescaler, PWM counter, targets, duties = 0; all LED outputs = 0; o_period_strobe = 0. Mid-period reset abandons the period; first boundary after release is 255*parm_pwm_prescale clocks later.
- Outputs registered: LED pin reflects compare of counter/duty from the previous cycle (1-clock latency).
- Input-to-duty latency: value present at boundary cycle takes effect in the period starting next; worst case ≈ 1 period + 1 clock (without fade).
- Input change on the boundary cycle itself is captured.
- parm_pwm_prescale = 1: tick every clock; behaviour otherwise identical.

## Configuration

- LED_PWM_FADE_EN defined: duty slews toward target by parm_fade_step per period as above; full 0→255 swing takes ceil(255/parm_fade_step) periods.
- LED_PWM_FADE_EN undefined: duty := target at every boundary (instant); fade arithmetic not synthesized; parm_fade_step ignored.

## Test plan

- Reset: hold i_srst 5 clocks with all inputs 0xFF → all outputs 0, o_period_strobe 0; release → first strobe 4081 clocks later (prescale 16).
- Static duty, fade off, prescale 2: red[0] = 0x80 → after first boundary, pin high 256 clocks, low 254 clocks per 510-clock period; 0x00 → never high; 0xFF → always high.
- Latch isolation: change green[1] 0x40→0xC0 mid-period → duty unchanged until next boundary; change on the boundary cycle → captured.
- Fade on, step 4: lumin[2] 0x00→0xFF → duty 4, 8, ... 252, 255 over 64 periods; then 0xFF→0x02 → ramps down, final step lands exactly on 0x02, no underflow.
- Channel independence: distinct values per LED across all 16 channels → each pin's high-count per period equals its own duty.
- Reset mid-fade: assert i_srst at period 10 of a ramp → all duties 0 next clock; resumes ramp from 0 after release.
